// File: rtl/palette_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// palette_arbiter_pkg
//   Shared definitions for the palette ROM arbiters: default parameter values
//   and the width function for the CPU starvation counter.
//   No ports (package).
// -----------------------------------------------------------------------------
package palette_arbiter_pkg;

   localparam int ADDR_SIZE_DEF    = 16;
   localparam int WORD_SIZE_DEF    = 20;
   localparam int STARVE_LIMIT_DEF = 15;

   // Counter must be able to hold the value STARVE_LIMIT itself.
   function automatic int starve_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/palette_arbiter.sv
// -----------------------------------------------------------------------------
// palette_arbiter
//   Shares one asynchronous palette ROM between the video scan-out pipeline
//   (priority, one lookup per cycle) and a CPU readback port (one outstanding
//   lookup, with a starvation guard that forces a CPU slot after STARVE_LIMIT
//   consecutive denials). The ROM address is driven combinationally; both
//   requesters get registered data one cycle after their grant.
//
//   Ports:
//     clk, reset_n              clock, synchronous active-low reset
//     vid_req_i, vid_addr_i     video lookup request/address
//     vid_ready_o               video granted this cycle (combinational)
//     vid_valid_o, vid_data_o   registered video result
//     cpu_req_i, cpu_addr_i     one-cycle CPU strobe, address captured on it
//     cpu_busy_o                CPU request pending (strobes ignored)
//     cpu_ack_o, cpu_data_o     one-cycle ack pulse, data held until next ack
//     rom_addr_o, rom_value_i   ROM address out, ROM data in
// -----------------------------------------------------------------------------
module palette_arbiter
   import palette_arbiter_pkg::*;
#(
   parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
   parameter int WORD_SIZE    = WORD_SIZE_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 vid_req_i,
   input  logic [ADDR_SIZE-1:0] vid_addr_i,
   output logic                 vid_ready_o,
   output logic                 vid_valid_o,
   output logic [WORD_SIZE-1:0] vid_data_o,
   input  logic                 cpu_req_i,
   input  logic [ADDR_SIZE-1:0] cpu_addr_i,
   output logic                 cpu_busy_o,
   output logic                 cpu_ack_o,
   output logic [WORD_SIZE-1:0] cpu_data_o,
   output logic [ADDR_SIZE-1:0] rom_addr_o,
   input  logic [WORD_SIZE-1:0] rom_value_i
);

   localparam int             SW         = starve_width(STARVE_LIMIT);
   localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

   logic                 pend_q,      pend_d;
   logic [ADDR_SIZE-1:0] pend_addr_q, pend_addr_d;
   logic [SW-1:0]        starve_q,    starve_d;
   logic                 vid_valid_q, vid_valid_d;
   logic [WORD_SIZE-1:0] vid_data_q,  vid_data_d;
   logic                 cpu_ack_q,   cpu_ack_d;
   logic [WORD_SIZE-1:0] cpu_data_q,  cpu_data_d;

   logic force_slot;
   logic cpu_gnt;
   logic vid_gnt;

   // Grant decision: video wins unless the CPU has waited STARVE_LIMIT cycles.
   always_comb begin
      force_slot = pend_q && (starve_q == STARVE_MAX);
      cpu_gnt    = pend_q && (!vid_req_i || force_slot);
      vid_gnt    = vid_req_i && !force_slot;
   end

   // Video address is the idle default so the ROM address is never X.
   assign rom_addr_o = cpu_gnt ? pend_addr_q : vid_addr_i;

   always_comb begin
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      starve_d    = starve_q;
      vid_valid_d = vid_gnt;
      vid_data_d  = vid_data_q;
      cpu_ack_d   = cpu_gnt;
      cpu_data_d  = cpu_data_q;

      // A strobe while a request is pending (including its grant cycle) is dropped.
      if (!pend_q && cpu_req_i) begin
         pend_d      = 1'b1;
         pend_addr_d = cpu_addr_i;
      end else if (cpu_gnt) begin
         pend_d = 1'b0;
      end

      if (!pend_q || cpu_gnt) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + SW'(1);
      end

      if (vid_gnt) begin
         vid_data_d = rom_value_i;
      end
      if (cpu_gnt) begin
         cpu_data_d = rom_value_i;
      end
   end

   // Result register stage: ROM data captured one edge after its grant.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         starve_q    <= '0;
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_data_q  <= '0;
      end else begin
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         starve_q    <= starve_d;
         vid_valid_q <= vid_valid_d;
         vid_data_q  <= vid_data_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_data_q  <= cpu_data_d;
      end
   end

   assign vid_ready_o = vid_gnt;
   assign vid_valid_o = vid_valid_q;
   assign vid_data_o  = vid_data_q;
   assign cpu_busy_o  = pend_q;
   assign cpu_ack_o   = cpu_ack_q;
   assign cpu_data_o  = cpu_data_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// -----------------------------------------------------------------------------
// tb_palette_arbiter
//   Directed bench for palette_arbiter with a behavioural ROM:
//   ROM[0x0010] = 0x12345, every other ROM[a] = 0x50000 | a.
// -----------------------------------------------------------------------------
module tb_palette_arbiter;

   localparam int ADDR_SIZE    = 16;
   localparam int WORD_SIZE    = 20;
   localparam int STARVE_LIMIT = 15;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 vid_req_i;
   logic [ADDR_SIZE-1:0] vid_addr_i;
   logic                 vid_ready_o;
   logic                 vid_valid_o;
   logic [WORD_SIZE-1:0] vid_data_o;
   logic                 cpu_req_i;
   logic [ADDR_SIZE-1:0] cpu_addr_i;
   logic                 cpu_busy_o;
   logic                 cpu_ack_o;
   logic [WORD_SIZE-1:0] cpu_data_o;
   logic [ADDR_SIZE-1:0] rom_addr_o;
   logic [WORD_SIZE-1:0] rom_value_i;

   int n_cmp = 0;
   int n_bad = 0;
   int acks;

   always #5 clk = ~clk;

   function automatic logic [WORD_SIZE-1:0] rom_f(input logic [ADDR_SIZE-1:0] a);
      if (a == 16'h0010) return 20'h12345;
      return 20'h50000 | {4'h0, a};
   endfunction

   assign rom_value_i = rom_f(rom_addr_o);

   palette_arbiter #(
      .ADDR_SIZE   (ADDR_SIZE),
      .WORD_SIZE   (WORD_SIZE),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .vid_req_i  (vid_req_i),
      .vid_addr_i (vid_addr_i),
      .vid_ready_o(vid_ready_o),
      .vid_valid_o(vid_valid_o),
      .vid_data_o (vid_data_o),
      .cpu_req_i  (cpu_req_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_busy_o (cpu_busy_o),
      .cpu_ack_o  (cpu_ack_o),
      .cpu_data_o (cpu_data_o),
      .rom_addr_o (rom_addr_o),
      .rom_value_i(rom_value_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Move to the next cycle: inputs are driven 1 time unit after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      vid_req_i  = 1'b1;
      vid_addr_i = '0;
      cpu_req_i  = 1'b0;
      cpu_addr_i = '0;
      next_cycle();

      // Reset held with video requesting
      for (int i = 0; i < 3; i++) begin
         reset_n    = 1'b0;
         vid_req_i  = 1'b1;
         vid_addr_i = 16'(i);
         @(negedge clk);
         chk("rst_vid_valid", 32'(vid_valid_o), 32'd0);
         chk("rst_cpu_ack",   32'(cpu_ack_o),   32'd0);
         chk("rst_cpu_busy",  32'(cpu_busy_o),  32'd0);
         next_cycle();
      end
      reset_n    = 1'b1;
      vid_addr_i = 16'h0003;
      @(negedge clk);
      chk("rel_vid_ready", 32'(vid_ready_o), 32'd1);
      chk("rel_vid_valid", 32'(vid_valid_o), 32'd0);
      chk("rel_vid_data",  32'(vid_data_o),  32'd0);
      chk("rel_cpu_data",  32'(cpu_data_o),  32'd0);
      next_cycle();
      vid_req_i = 1'b0;
      @(negedge clk);
      chk("first_vid_valid", 32'(vid_valid_o), 32'd1);
      chk("first_vid_data",  32'(vid_data_o),  32'h50003);
      next_cycle();

      // Idle CPU read of ROM[0x0010]
      cpu_req_i  = 1'b1;
      cpu_addr_i = 16'h0010;
      @(negedge clk);
      chk("idle_busy_n",  32'(cpu_busy_o), 32'd0);
      next_cycle();
      cpu_req_i = 1'b0;
      @(negedge clk);
      chk("idle_busy_n1", 32'(cpu_busy_o), 32'd1);
      chk("idle_ack_n1",  32'(cpu_ack_o),  32'd0);
      chk("idle_rom_adr", 32'(rom_addr_o), 32'h0010);
      next_cycle();
      @(negedge clk);
      chk("idle_ack_n2",  32'(cpu_ack_o),  32'd1);
      chk("idle_data_n2", 32'(cpu_data_o), 32'h12345);
      chk("idle_busy_n2", 32'(cpu_busy_o), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("idle_ack_n3",  32'(cpu_ack_o),  32'd0);
      chk("idle_hold_n3", 32'(cpu_data_o), 32'h12345);
      next_cycle();

      // Video stream, addresses 0..7 back to back
      for (int k = 0; k < 8; k++) begin
         vid_req_i  = 1'b1;
         vid_addr_i = 16'(k);
         @(negedge clk);
         chk("vs_ready", 32'(vid_ready_o), 32'd1);
         if (k > 0) begin
            chk("vs_valid", 32'(vid_valid_o), 32'd1);
            chk("vs_data",  32'(vid_data_o),  32'h50000 + 32'(k - 1));
         end
         next_cycle();
      end
      vid_req_i = 1'b0;
      @(negedge clk);
      chk("vs_valid_last", 32'(vid_valid_o), 32'd1);
      chk("vs_data_last",  32'(vid_data_o),  32'h50007);
      next_cycle();
      @(negedge clk);
      chk("vs_valid_end", 32'(vid_valid_o), 32'd0);
      chk("vs_data_hold", 32'(vid_data_o),  32'h50007);
      next_cycle();

      // Starvation: video held, CPU strobe at N, forced slot at N+16
      vid_req_i  = 1'b1;
      vid_addr_i = 16'h0040;
      cpu_req_i  = 1'b1;
      cpu_addr_i = 16'h0222;
      @(negedge clk);
      chk("st_ready_n", 32'(vid_ready_o), 32'd1);
      next_cycle();
      cpu_req_i = 1'b0;
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         chk("st_busy",  32'(cpu_busy_o),  32'd1);
         chk("st_ready", 32'(vid_ready_o), (j == 16) ? 32'd0 : 32'd1);
         chk("st_ack",   32'(cpu_ack_o),   32'd0);
         if (j == 16) begin
            chk("st_rom_adr", 32'(rom_addr_o),  32'h0222);
            chk("st_vvalid",  32'(vid_valid_o), 32'd1);
         end
         next_cycle();
      end
      // N+17: ack; also a strobe here must be accepted
      vid_req_i  = 1'b0;
      cpu_req_i  = 1'b1;
      cpu_addr_i = 16'h0333;
      @(negedge clk);
      chk("st_ack_n17",    32'(cpu_ack_o),   32'd1);
      chk("st_data_n17",   32'(cpu_data_o),  32'h50222);
      chk("st_vvalid_n17", 32'(vid_valid_o), 32'd0);
      chk("st_busy_n17",   32'(cpu_busy_o),  32'd0);
      next_cycle();
      cpu_req_i = 1'b0;
      @(negedge clk);
      chk("ackcyc_busy",    32'(cpu_busy_o), 32'd1);
      chk("ackcyc_rom_adr", 32'(rom_addr_o), 32'h0333);
      next_cycle();
      @(negedge clk);
      chk("ackcyc_ack",  32'(cpu_ack_o),  32'd1);
      chk("ackcyc_data", 32'(cpu_data_o), 32'h50333);
      next_cycle();

      // Dropped strobe: second address while busy is ignored
      vid_req_i  = 1'b1;
      vid_addr_i = 16'h0041;
      cpu_req_i  = 1'b1;
      cpu_addr_i = 16'h0444;
      @(negedge clk);
      next_cycle();
      cpu_addr_i = 16'h0555;
      @(negedge clk);
      chk("drop_busy", 32'(cpu_busy_o), 32'd1);
      next_cycle();
      cpu_req_i = 1'b0;
      vid_req_i = 1'b0;
      @(negedge clk);
      chk("drop_rom_adr", 32'(rom_addr_o), 32'h0444);
      next_cycle();
      acks = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         if (j == 0) chk("drop_data", 32'(cpu_data_o), 32'h50444);
         if (cpu_ack_o) acks++;
         next_cycle();
      end
      chk("drop_ack_count", 32'(acks), 32'd1);
      chk("drop_data_hold", 32'(cpu_data_o), 32'h50444);

      // Reset mid-request under video load
      vid_req_i  = 1'b1;
      vid_addr_i = 16'h0042;
      cpu_req_i  = 1'b1;
      cpu_addr_i = 16'h0666;
      @(negedge clk);
      next_cycle();
      cpu_req_i = 1'b0;
      @(negedge clk);
      chk("mid_busy_pre", 32'(cpu_busy_o), 32'd1);
      next_cycle();
      reset_n = 1'b0;
      @(negedge clk);
      next_cycle();
      reset_n   = 1'b1;
      vid_req_i = 1'b0;
      acks = 0;
      @(negedge clk);
      chk("mid_busy_post", 32'(cpu_busy_o), 32'd0);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (cpu_ack_o) acks++;
         next_cycle();
      end
      chk("mid_no_ack", 32'(acks), 32'd0);
      chk("mid_busy_end", 32'(cpu_busy_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
